// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : 32 x N register file with two combinational read ports, one
//               write-back port and a 2-bit pending-write counter per
//               register. The counters drive the read-port busy flags and the
//               decode stall.
//               Optional macro WB_BYPASS_EN forwards the current write-back
//               data to a read port that addresses the register being written.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         wr_en_wb,
    input  logic         wd_sel_wb,
    input  logic [4:0]   rw_wb,
    input  logic [N-1:0] alu_result_wb,
    input  logic [N-1:0] rd_wb,
    input  logic [4:0]   ra1,
    input  logic [4:0]   ra2,
    output logic [N-1:0] rd1,
    output logic [N-1:0] rd2,
    input  logic         issue_en,
    input  logic [4:0]   issue_rw,
    output logic         busy1,
    output logic         busy2,
    output logic         stall
);

    logic [N-1:0] regs_q  [32];
    logic [1:0]   count_q [32];
    logic [1:0]   count_d [32];

    logic [N-1:0] w_wdata;
    logic         w_wb_hit;
    logic         w_overflow;
    logic         w_issue_ok;

    assign w_wdata  = wd_sel_wb ? rd_wb : alu_result_wb;
    // Index 0 is hard-wired, so a write-back to it has no effect anywhere.
    assign w_wb_hit = wr_en_wb && (rw_wb != 5'd0);

    // Combinational read ports and their busy flags.
    always_comb begin
        rd1   = (ra1 == 5'd0) ? '0 : regs_q[ra1];
        rd2   = (ra2 == 5'd0) ? '0 : regs_q[ra2];
        busy1 = (ra1 != 5'd0) && (count_q[ra1] != 2'd0);
        busy2 = (ra2 != 5'd0) && (count_q[ra2] != 2'd0);
`ifdef WB_BYPASS_EN
        // The write landing this cycle resolves the last outstanding write,
        // so the reader may take the forwarded data instead of waiting.
        if (w_wb_hit && (ra1 == rw_wb)) begin
            rd1 = w_wdata;
            if (count_q[ra1] <= 2'd1) busy1 = 1'b0;
        end
        if (w_wb_hit && (ra2 == rw_wb)) begin
            rd2 = w_wdata;
            if (count_q[ra2] <= 2'd1) busy2 = 1'b0;
        end
`endif
    end

    // A full counter can only accept another issue if a write-back to the
    // same register retires one in the same cycle.
    assign w_overflow = issue_en && (count_q[issue_rw] == 2'd3) &&
                        !(w_wb_hit && (rw_wb == issue_rw));
    assign stall      = busy1 || busy2 || w_overflow;
    assign w_issue_ok = issue_en && (issue_rw != 5'd0) && !stall;

    // Next value of each pending counter: +1 on accepted issue, -1 on
    // write-back (saturating at 0), unchanged when both hit the same index.
    always_comb begin
        count_d[0] = 2'd0;
        for (int i = 1; i < 32; i++) begin
            logic inc;
            logic dec;
            inc = w_issue_ok && (issue_rw == 5'(i));
            dec = w_wb_hit && (rw_wb == 5'(i));
            count_d[i] = count_q[i];
            if (inc && !dec) begin
                count_d[i] = count_q[i] + 2'd1;
            end else if (dec && !inc && (count_q[i] != 2'd0)) begin
                count_d[i] = count_q[i] - 2'd1;
            end
        end
    end

    // Register storage and counter state; reset discards any same-cycle
    // write-back or issue.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i]  <= '0;
                count_q[i] <= 2'd0;
            end
        end else begin
            if (w_wb_hit) regs_q[rw_wb] <= w_wdata;
            for (int i = 0; i < 32; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Table-driven self-checking bench for wb_regfile. Each table
//               row is one clock cycle: inputs are applied after the falling
//               edge and outputs are compared before the next rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

`ifdef WB_BYPASS_EN
    localparam bit B = 1'b1;
`else
    localparam bit B = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en_wb, wd_sel_wb, issue_en;
    logic [4:0]  rw_wb, ra1, ra2, issue_rw;
    logic [31:0] alu_result_wb, rd_wb, rd1, rd2;
    logic        busy1, busy2, stall;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst, we, sel;
        logic [4:0]  rw;
        logic [31:0] alu, rdw;
        logic [4:0]  a1, a2;
        logic        ie;
        logic [4:0]  irw;
        logic [31:0] e_rd1, e_rd2;
        logic        e_b1, e_b2, e_st;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    wb_regfile #(.N(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .wr_en_wb      (wr_en_wb),
        .wd_sel_wb     (wd_sel_wb),
        .rw_wb         (rw_wb),
        .alu_result_wb (alu_result_wb),
        .rd_wb         (rd_wb),
        .ra1           (ra1),
        .ra2           (ra2),
        .rd1           (rd1),
        .rd2           (rd2),
        .issue_en      (issue_en),
        .issue_rw      (issue_rw),
        .busy1         (busy1),
        .busy2         (busy2),
        .stall         (stall)
    );

    task automatic add(input int unsigned rst, we, sel, rw, alu, rdw, a1, a2,
                       ie, irw, erd1, erd2, eb1, eb2, est);
        vec_t v;
        v.rst = rst[0];  v.we = we[0];  v.sel = sel[0];  v.rw = 5'(rw);
        v.alu = alu;     v.rdw = rdw;   v.a1 = 5'(a1);   v.a2 = 5'(a2);
        v.ie = ie[0];    v.irw = 5'(irw);
        v.e_rd1 = erd1;  v.e_rd2 = erd2;
        v.e_b1 = eb1[0]; v.e_b2 = eb2[0]; v.e_st = est[0];
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst;  wr_en_wb = v.we;  wd_sel_wb = v.sel;  rw_wb = v.rw;
        alu_result_wb = v.alu;  rd_wb = v.rdw;  ra1 = v.a1;  ra2 = v.a2;
        issue_en = v.ie;  issue_rw = v.irw;
    endtask

    initial begin
        // rst we sel rw alu rdw a1 a2 ie irw | rd1 rd2 b1 b2 st
        add(0,0,0,0,0,0, 5,7, 0,0, 0,0, 0,0,0);                           // post-reset
        add(0,1,0,5,32'hAA,32'h1111, 5,0, 0,0, B?32'hAA:0, 0, 0,0,0);     // r5 via ALU
        add(0,1,0,0,32'h1234,0, 5,0, 0,0, 32'hAA, 0, 0,0,0);              // write r0
        add(0,0,0,0,0,0, 0,5, 0,0, 0,32'hAA, 0,0,0);
        add(0,1,1,7,1,32'hDEADBEEF, 7,0, 0,0, B?32'hDEADBEEF:0, 0, 0,0,0); // r7 via mem
        add(0,0,0,0,0,0, 7,0, 0,0, 32'hDEADBEEF, 0, 0,0,0);
        add(0,0,0,0,0,0, 0,0, 1,3, 0,0, 0,0,0);                           // issue r3
        add(0,0,0,0,0,0, 3,0, 0,0, 0,0, 1,0,1);
        add(0,1,0,3,32'h55,0, 3,0, 0,0, B?32'h55:0, 0, B?0:1,0,B?0:1);    // wb r3
        add(0,0,0,0,0,0, 3,0, 0,0, 32'h55, 0, 0,0,0);
        add(0,1,0,9,32'h10,0, 0,0, 0,0, 0,0, 0,0,0);                      // r9 = 0x10
        add(0,0,0,0,0,0, 0,0, 1,9, 0,0, 0,0,0);                           // issue r9
        add(0,1,0,9,32'h77,0, 0,9, 0,0, 0, B?32'h77:32'h10, 0,B?0:1,B?0:1);
        add(0,0,0,0,0,0, 0,9, 0,0, 0,32'h77, 0,0,0);
        add(0,0,0,0,0,0, 0,0, 1,4, 0,0, 0,0,0);                           // issue r4 x3
        add(0,0,0,0,0,0, 0,0, 1,4, 0,0, 0,0,0);
        add(0,0,0,0,0,0, 0,0, 1,4, 0,0, 0,0,0);
        add(0,0,0,0,0,0, 0,0, 1,4, 0,0, 0,0,1);                           // overflow
        add(0,1,0,4,32'h44,0, 0,0, 1,4, 0,0, 0,0,0);                      // issue+wb r4
        add(0,0,0,0,0,0, 0,0, 1,4, 0,0, 0,0,1);                           // still 3
        add(0,0,0,0,0,0, 4,0, 0,0, 32'h44, 0, 1,0,1);
        add(0,1,0,4,32'h41,0, 4,0, 0,0, B?32'h41:32'h44, 0, 1,0,1);       // drain 3->2
        add(0,1,0,4,32'h42,0, 4,0, 0,0, B?32'h42:32'h41, 0, 1,0,1);       // 2->1
        add(0,1,0,4,32'h43,0, 4,0, 0,0, B?32'h43:32'h42, 0, B?0:1,0,B?0:1); // 1->0
        add(0,0,0,0,0,0, 4,0, 0,0, 32'h43, 0, 0,0,0);
        add(0,1,0,4,32'h45,0, 4,0, 0,0, B?32'h45:32'h43, 0, 0,0,0);       // wb at 0
        add(0,0,0,0,0,0, 0,0, 1,4, 0,0, 0,0,0);                           // no underflow
        add(0,0,0,0,0,0, 4,0, 0,0, 32'h45, 0, 1,0,1);
        add(0,1,0,10,32'hA0,0, 0,0, 1,10, 0,0, 0,0,0);                    // issue+wb r10 at 0
        add(0,0,0,0,0,0, 10,0, 0,0, 32'hA0, 0, 0,0,0);
        add(0,1,0,2,32'h99,0, 0,0, 0,0, 0,0, 0,0,0);                      // r2 = 0x99
        add(0,0,0,0,0,0, 2,0, 1,6, 32'h99, 0, 0,0,0);                     // issue r6
        add(1,1,0,2,32'hFF,0, 2,6, 1,6, B?32'hFF:32'h99, 0, 0,1,1);       // reset cycle
        add(0,0,0,0,0,0, 2,6, 0,0, 0,0, 0,0,0);

        drive('{rst:1'b1, default:'0});
        repeat (2) @(posedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            drive(vecs[i]);
            #2;
            check("rd1",   i, rd1,          vecs[i].e_rd1);
            check("rd2",   i, rd2,          vecs[i].e_rd2);
            check("busy1", i, 32'(busy1),   32'(vecs[i].e_b1));
            check("busy2", i, 32'(busy2),   32'(vecs[i].e_b2));
            check("stall", i, 32'(stall),   32'(vecs[i].e_st));
        end

        // After the reset, every index must read zero and be idle.
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            drive('{default:'0});
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #2;
            check("rst_rd1",   100 + i, rd1,         32'h0);
            check("rst_rd2",   100 + i, rd2,         32'h0);
            check("rst_busy",  100 + i, 32'({busy1, busy2}), 32'h0);
            check("rst_stall", 100 + i, 32'(stall),  32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter: N, default 32, data width of every register and data port.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wr_en_wb  input  1  write-back enable from the MEM/WB stage.
REQ-005 wd_sel_wb  input  1  write-data select: 0 selects alu_result_wb, 1 selects rd_wb.
REQ-006 rw_wb  input  5  destination register index for write-back.
REQ-007 alu_result_wb  input  N  ALU result to be written back.
REQ-008 rd_wb  input  N  memory read data to be written back.
REQ-009 ra1, ra2  input  5 each  read-port register indices.
REQ-010 rd1, rd2  output  N each  read-port data, combinational from ra1/ra2.
REQ-011 issue_en  input  1  decode issues an instruction that will write issue_rw.
REQ-012 issue_rw  input  5  destination index being reserved at issue.
REQ-013 busy1, busy2  output  1 each  the register addressed by ra1/ra2 has an outstanding write.
REQ-014 stall  output  1  decode must hold; the issue in the current cycle is not accepted.

Function
REQ-015 Storage SHALL be 32 registers of N bits; register 0 SHALL read as zero and SHALL ignore writes.
REQ-016 Write data SHALL be rd_wb when wd_sel_wb=1, else alu_result_wb.
REQ-017 When wr_en_wb=1 and rw_wb!=0, the register SHALL be updated at the rising edge; the new value SHALL be visible on rd1/rd2 in the following cycle.
REQ-018 Reads SHALL be combinational, with no latency relative to ra1/ra2.
REQ-019 Each register index 1..31 SHALL have a 2-bit pending counter; index 0 SHALL never be pending.
REQ-020 An accepted issue (issue_en=1, issue_rw!=0, stall=0) SHALL increment count[issue_rw].
REQ-021 A write-back (wr_en_wb=1, rw_wb!=0) SHALL decrement count[rw_wb]; at zero the counter SHALL stay at 0 (no underflow) and the register write SHALL still occur.
REQ-022 An accepted issue and a write-back to the same index in one cycle SHALL leave the counter unchanged.
REQ-023 busyk SHALL be 1 when count[rak]!=0, except as relaxed by REQ-029; busyk SHALL be 0 for rak=0.
REQ-024 stall SHALL be busy1 OR busy2 OR overflow.
REQ-025 overflow SHALL be 1 when issue_en=1 and count[issue_rw]=3 and no write-back to issue_rw occurs in the same cycle.
REQ-026 A stalled issue SHALL NOT change any counter.
REQ-027 issue_en=0 SHALL leave counters affected by write-back only.

Reset
REQ-028 While reset=1 at a rising edge, all 32 registers and all counters SHALL clear to 0, and any write-back or issue in that cycle SHALL be discarded; on the next cycle rd1=rd2=0, busy1=busy2=0 and stall=0.

Configuration
REQ-029 Macro WB_BYPASS_EN: when defined, if wr_en_wb=1, rw_wb!=0 and rak=rw_wb, rdk SHALL return the current write data, and busyk SHALL be 0 when count[rak]<=1.
REQ-030 Without WB_BYPASS_EN, rdk SHALL return the stored value, and busyk SHALL follow REQ-023 unmodified.

Verification
REQ-031 Write 0x0000_00AA to r5 via ALU path (wd_sel_wb=0), ra1=5 next cycle -> rd1=0x0000_00AA; write 0x1234 to r0 -> rd for ra=0 stays 0.
REQ-032 wd_sel_wb=1, rd_wb=0xDEAD_BEEF, alu_result_wb=0x1, rw_wb=7 -> r7=0xDEAD_BEEF.
REQ-033 Issue r3, ra1=3 next cycle -> busy1=1, stall=1; write-back r3 with 0x55 -> next cycle busy1=0, stall=0, rd1=0x55.
REQ-034 Same-cycle write 0x77 to r9 with ra2=9: WB_BYPASS_EN defined -> rd2=0x77, busy2=0; undefined -> rd2=old value and busy2 follows count[9].
REQ-035 Issue r4 three times, then a fourth issue -> stall=1 and count stays 3; fourth issue with a simultaneous write-back to r4 -> accepted and count stays 3.
REQ-036 Load r2=0x99 and issue r6 -> assert reset for one cycle -> rd=0 for every index, busy1=busy2=0, stall=0.
